// File: rtl/alu_serial_sequencer.sv
// alu_serial_sequencer
//   Bit-serial ALU front end. Accepts a WIDTH-bit operation over a valid/ready
//   handshake, computes it LSB-first through a 1-bit full-adder slice with a
//   registered carry, then presents Result/Cout (and optional flags) over an
//   output valid/ready handshake. One op every WIDTH+2 clocks.
//
//   Optional feature macro: ALU_SERIAL_FLAGS_EN (adds Zero/Negative/Overflow).
//
// Ports
//   clk       in   1      system clock, rising edge
//   rst       in   1      synchronous reset, active-high
//   InValid   in   1      operation presented on A/B/opsel/Cin
//   InReady   out  1      sequencer can accept an operation
//   A, B      in   WIDTH  operands
//   opsel     in   3      0 add,1 subwb,2 mov,3 sub,4 inc,5 dec,6 addinc,7 mov
//   Cin       in   1      external carry-in (subwb only)
//   OutValid  out  1      Result/flags valid
//   OutReady  in   1      consumer accepts result
//   Result    out  WIDTH  computed result
//   Cout      out  1      carry out of MSB (1 = no borrow for subtracts)
//   Zero, Negative, Overflow  out 1 each (ALU_SERIAL_FLAGS_EN only)
module alu_serial_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       opsel,
  input  logic             Cin,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Cout
`ifdef ALU_SERIAL_FLAGS_EN
  ,
  output logic             Zero,
  output logic             Negative,
  output logic             Overflow
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_HOLD
  } state_e;

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] res_q;
  logic             cout_q;

  logic [WIDTH-1:0] bop_d;
  logic             c0_d;
  logic             s_d;
  logic             carry_d;

  // B-side operand and initial carry for each opcode
  always_comb begin
    bop_d = '0;
    c0_d  = 1'b0;
    case (opsel)
      3'd0: begin bop_d = B;   c0_d = 1'b0; end
      3'd1: begin bop_d = ~B;  c0_d = Cin;  end
      3'd3: begin bop_d = ~B;  c0_d = 1'b1; end
      3'd4: begin bop_d = '0;  c0_d = 1'b1; end
      3'd5: begin bop_d = '1;  c0_d = 1'b0; end
      3'd6: begin bop_d = B;   c0_d = 1'b1; end
      default: begin bop_d = '0; c0_d = 1'b0; end
    endcase
  end

  // 1-bit full-adder slice
  always_comb begin
    s_d     = a_q[0] ^ b_q[0] ^ carry_q;
    carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  end

`ifdef ALU_SERIAL_FLAGS_EN
  logic zacc_q;
  logic zero_q;
  logic neg_q;
  logic ovf_q;
  assign Zero     = zero_q;
  assign Negative = neg_q;
  assign Overflow = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      res_q       <= '0;
      cout_q      <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
      zacc_q      <= 1'b1;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (InValid) begin
            a_q        <= A;
            b_q        <= bop_d;
            carry_q    <= c0_d;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_SHIFT;
`ifdef ALU_SERIAL_FLAGS_EN
            zacc_q     <= 1'b1;
`endif
          end
        end
        S_SHIFT: begin
          carry_q <= carry_d;
          res_q   <= {s_d, res_q[WIDTH-1:1]};
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
`ifdef ALU_SERIAL_FLAGS_EN
          zacc_q  <= zacc_q & ~s_d;
`endif
          if (cnt_q == CNT_LAST) begin
            cout_q      <= carry_d;
            out_valid_q <= 1'b1;
            state_q     <= S_HOLD;
`ifdef ALU_SERIAL_FLAGS_EN
            // carry_q here is the carry into the MSB
            zero_q      <= zacc_q & ~s_d;
            neg_q       <= s_d;
            ovf_q       <= carry_q ^ carry_d;
`endif
          end
        end
        S_HOLD: begin
          if (OutReady) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign InReady  = in_ready_q & ~rst;
  assign OutValid = out_valid_q;
  assign Result   = res_q;
  assign Cout     = cout_q;

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed testbench for alu_serial_sequencer (WIDTH=32).
// Flag checks are compiled in when ALU_SERIAL_FLAGS_EN is defined.
module tb_alu_serial_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         InValid;
  logic         InReady;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   opsel;
  logic         Cin;
  logic         OutValid;
  logic         OutReady;
  logic [W-1:0] Result;
  logic         Cout;
`ifdef ALU_SERIAL_FLAGS_EN
  logic         Zero;
  logic         Negative;
  logic         Overflow;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_serial_sequencer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .InValid  (InValid),
    .InReady  (InReady),
    .A        (A),
    .B        (B),
    .opsel    (opsel),
    .Cin      (Cin),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Result   (Result),
    .Cout     (Cout)
`ifdef ALU_SERIAL_FLAGS_EN
    ,
    .Zero     (Zero),
    .Negative (Negative),
    .Overflow (Overflow)
`endif
  );

  // Stimulus only: present an op for one edge, scramble operands afterwards,
  // then count edges until OutValid (bounded at 100).
  task automatic do_op(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic cin, output int lat);
    opsel = op; A = a; B = b; Cin = cin; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0; A = ~a; B = ~b; Cin = ~cin; opsel = 3'd0;
    lat = 0;
    while (!OutValid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume();
    OutReady = 1'b1;
    @(posedge clk); #1;
    OutReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; InValid = 1'b0; OutReady = 1'b0;
    A = '0; B = '0; opsel = 3'd0; Cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL rst_inready got=%b exp=0", InReady); end
    checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL rst_outvalid got=%b exp=0", OutValid); end
    checks++; if (Result !== 32'h0) begin failures++; $display("FAIL rst_result got=%h exp=0", Result); end
    checks++; if (Cout !== 1'b0) begin failures++; $display("FAIL rst_cout got=%b exp=0", Cout); end
`ifdef ALU_SERIAL_FLAGS_EN
    checks++; if ({Zero, Negative, Overflow} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {Zero, Negative, Overflow}); end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL post_rst_inready got=%b exp=1", InReady); end
    checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL post_rst_outvalid got=%b exp=0", OutValid); end
  endtask

  task automatic test_add_carry();
    int lat;
    checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL add_inready got=%b exp=1", InReady); end
    do_op(3'd0, 32'hFFFF_FFFF, 32'h1, 1'b0, lat);
    checks++; if (lat !== 32) begin failures++; $display("FAIL add_latency got=%0d exp=32", lat); end
    checks++; if (Result !== 32'h0) begin failures++; $display("FAIL add_result got=%h exp=00000000", Result); end
    checks++; if (Cout !== 1'b1) begin failures++; $display("FAIL add_cout got=%b exp=1", Cout); end
`ifdef ALU_SERIAL_FLAGS_EN
    checks++; if ({Zero, Negative, Overflow} !== 3'b100) begin failures++; $display("FAIL add_flags got=%b exp=100", {Zero, Negative, Overflow}); end
`endif
    consume();
  endtask

  task automatic test_sub();
    int lat;
    do_op(3'd3, 32'd5, 32'd7, 1'b0, lat);
    checks++; if (lat !== 32) begin failures++; $display("FAIL sub_latency got=%0d exp=32", lat); end
    checks++; if (Result !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sub_result got=%h exp=fffffffe", Result); end
    checks++; if (Cout !== 1'b0) begin failures++; $display("FAIL sub_cout got=%b exp=0", Cout); end
`ifdef ALU_SERIAL_FLAGS_EN
    checks++; if ({Zero, Negative, Overflow} !== 3'b010) begin failures++; $display("FAIL sub_flags got=%b exp=010", {Zero, Negative, Overflow}); end
`endif
    consume();
    do_op(3'd1, 32'd5, 32'd3, 1'b0, lat);
    checks++; if (Result !== 32'h1) begin failures++; $display("FAIL subwb_result got=%h exp=00000001", Result); end
    checks++; if (Cout !== 1'b1) begin failures++; $display("FAIL subwb_cout got=%b exp=1", Cout); end
    consume();
    // Cin=1 on subwb behaves like plain sub: 5-3 = 2
    do_op(3'd1, 32'd5, 32'd3, 1'b1, lat);
    checks++; if (Result !== 32'h2) begin failures++; $display("FAIL subwb_cin1_result got=%h exp=00000002", Result); end
    consume();
  endtask

  task automatic test_overflow();
    int lat;
    do_op(3'd0, 32'h7FFF_FFFF, 32'h1, 1'b0, lat);
    checks++; if (Result !== 32'h8000_0000) begin failures++; $display("FAIL ovf_result got=%h exp=80000000", Result); end
    checks++; if (Cout !== 1'b0) begin failures++; $display("FAIL ovf_cout got=%b exp=0", Cout); end
`ifdef ALU_SERIAL_FLAGS_EN
    checks++; if ({Zero, Negative, Overflow} !== 3'b011) begin failures++; $display("FAIL ovf_flags got=%b exp=011", {Zero, Negative, Overflow}); end
`endif
    consume();
  endtask

  task automatic test_inc_dec_mov();
    int lat;
    do_op(3'd4, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, lat);
    checks++; if (Result !== 32'h0) begin failures++; $display("FAIL inc_result got=%h exp=00000000", Result); end
    checks++; if (Cout !== 1'b1) begin failures++; $display("FAIL inc_cout got=%b exp=1", Cout); end
    consume();
    do_op(3'd5, 32'h0, 32'h1234, 1'b0, lat);
    checks++; if (Result !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dec_result got=%h exp=ffffffff", Result); end
    checks++; if (Cout !== 1'b0) begin failures++; $display("FAIL dec_cout got=%b exp=0", Cout); end
    consume();
    do_op(3'd2, 32'h1234, 32'hFFFF, 1'b1, lat);
    checks++; if (Result !== 32'h1234) begin failures++; $display("FAIL mov_result got=%h exp=00001234", Result); end
    checks++; if (Cout !== 1'b0) begin failures++; $display("FAIL mov_cout got=%b exp=0", Cout); end
    consume();
    do_op(3'd7, 32'h1234, 32'hFFFF, 1'b1, lat);
    checks++; if (Result !== 32'h1234) begin failures++; $display("FAIL op7_result got=%h exp=00001234", Result); end
    consume();
    do_op(3'd6, 32'd10, 32'd20, 1'b0, lat);
    checks++; if (Result !== 32'd31) begin failures++; $display("FAIL addinc_result got=%h exp=0000001f", Result); end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    do_op(3'd0, 32'h0000_1111, 32'h0000_2222, 1'b0, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      InValid = (i == 4);
      A = 32'hDEAD_BEEF; B = 32'h1; opsel = 3'd0;
      @(posedge clk); #1;
      if (OutValid !== 1'b1 || Result !== 32'h0000_3333 || InReady !== 1'b0) bad++;
    end
    InValid = 1'b0;
    checks++; if (bad !== 0) begin failures++; $display("FAIL hold_stable bad_cycles=%0d exp=0", bad); end
    consume();
    checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL hold_release_inready got=%b exp=1", InReady); end
    checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL hold_release_outvalid got=%b exp=0", OutValid); end
    @(posedge clk); #1;
    checks++; if (Result !== 32'h0000_3333) begin failures++; $display("FAIL idle_result_hold got=%h exp=00003333", Result); end
    checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL idle_no_accept got=%b exp=1", InReady); end
  endtask

  task automatic test_reset_abort();
    int lat;
    int bad;
    opsel = 3'd0; A = 32'h0000_0005; B = 32'h0000_0006; Cin = 1'b0; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL abort_inready_in_rst got=%b exp=0", InReady); end
    rst = 1'b0;
    #1;
    checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL abort_inready got=%b exp=1", InReady); end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (OutValid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL abort_outvalid pulses=%0d exp=0", bad); end
    do_op(3'd0, 32'd3, 32'd4, 1'b0, lat);
    checks++; if (lat !== 32) begin failures++; $display("FAIL abort_next_latency got=%0d exp=32", lat); end
    checks++; if (Result !== 32'd7) begin failures++; $display("FAIL abort_next_result got=%h exp=00000007", Result); end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    do_op(3'd0, 32'h1000_0000, 32'h2000_0001, 1'b0, lat);
    consume();
    do_op(3'd3, 32'd100, 32'd1, 1'b0, lat);
    checks++; if (lat !== 32) begin failures++; $display("FAIL b2b_latency got=%0d exp=32", lat); end
    checks++; if (Result !== 32'd99) begin failures++; $display("FAIL b2b_result got=%h exp=00000063", Result); end
    checks++; if (Cout !== 1'b1) begin failures++; $display("FAIL b2b_cout got=%b exp=1", Cout); end
    consume();
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_sub();
    test_overflow();
    test_inc_dec_mov();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
